// File: rtl/load_extend_ctrl_if.sv
// +--------------------------------------------------------------------+
// | load_extend_ctrl_if                                                |
// | Pipeline load request and data-memory handshake bundle.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface load_extend_ctrl_if;
   logic        LdReq;
   logic [2:0]  LdType;
   logic [31:0] LdAddr;
   logic        Flush;
   logic        MemReq;
   logic [31:0] MemAddr;
   logic        MemAck;
   logic [31:0] MemRdata;
   logic [31:0] LdData;
   logic        LdValid;
   logic        Stall;
   logic        Err;

   // pipeline plus memory side
   modport master (
      output LdReq, LdType, LdAddr, Flush, MemAck, MemRdata,
      input  MemReq, MemAddr, LdData, LdValid, Stall, Err
   );

   // load controller side
   modport slave (
      input  LdReq, LdType, LdAddr, Flush, MemAck, MemRdata,
      output MemReq, MemAddr, LdData, LdValid, Stall, Err
   );
endinterface

`default_nettype wire

// File: rtl/load_extend_ctrl.sv
// +--------------------------------------------------------------------+
// | load_extend_ctrl                                                   |
// | Multi-cycle load controller: word request, lane select, extension. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module load_extend_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  wire logic         Clk,
   input  wire logic         Reset_n,
   load_extend_ctrl_if.slave bus
);

   localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);
   localparam logic [2:0] c_lh       = 3'b001;
   localparam logic [2:0] c_lhu      = 3'b010;
   localparam logic [2:0] c_lb       = 3'b011;
   localparam logic [2:0] c_lbu      = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nx;
   logic        w_aligned;
   logic        w_accept;
   logic        w_misalign;
   logic        w_capture;
   logic        w_timeout;
   logic        r_memreq;
   logic [31:0] r_memaddr;
   logic [31:0] r_lddata;
   logic        r_err;
   logic [7:0]  r_cnt;
   logic [2:0]  r_type;
   logic [1:0]  r_ofs;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;

   always_comb begin
      w_aligned = 1'b1;
      case (bus.LdType)
         c_lh, c_lhu: w_aligned = ~bus.LdAddr[0];
         c_lb, c_lbu: w_aligned = 1'b1;
         default:     w_aligned = (bus.LdAddr[1:0] == 2'b00);
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Flush outranks a same-cycle ack; an ack outranks an expiring timeout.
   always_comb begin
      w_state_nx = r_state;
      w_accept   = 1'b0;
      w_misalign = 1'b0;
      w_capture  = 1'b0;
      w_timeout  = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            w_state_nx = ST_IDLE;
            if (bus.LdReq) begin
               if (w_aligned) begin
                  w_state_nx = ST_ISSUE;
                  w_accept   = 1'b1;
               end else begin
                  w_misalign = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            if (bus.Flush) begin
               w_state_nx = ST_IDLE;
            end else if (bus.MemAck) begin
               w_state_nx = ST_DONE;
               w_capture  = 1'b1;
            end else if (r_cnt == c_tmo_last) begin
               w_state_nx = ST_IDLE;
               w_timeout  = 1'b1;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      w_byte = bus.MemRdata[7:0];
      case (r_ofs)
         2'd1:    w_byte = bus.MemRdata[15:8];
         2'd2:    w_byte = bus.MemRdata[23:16];
         2'd3:    w_byte = bus.MemRdata[31:24];
         default: w_byte = bus.MemRdata[7:0];
      endcase
      w_half = r_ofs[1] ? bus.MemRdata[31:16] : bus.MemRdata[15:0];
      case (r_type)
         c_lb:    w_ext = {{24{w_byte[7]}}, w_byte};
         c_lbu:   w_ext = {24'd0, w_byte};
         c_lh:    w_ext = {{16{w_half[15]}}, w_half};
         c_lhu:   w_ext = {16'd0, w_half};
         default: w_ext = bus.MemRdata;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_memreq  <= 1'b0;
         r_memaddr <= 32'd0;
         r_lddata  <= 32'd0;
         r_err     <= 1'b0;
         r_cnt     <= 8'd0;
         r_type    <= 3'd0;
         r_ofs     <= 2'd0;
      end else begin
         r_err <= w_misalign | w_timeout;
         if (w_accept) begin
            r_memreq  <= 1'b1;
            r_memaddr <= {bus.LdAddr[31:2], 2'b00};
            r_type    <= bus.LdType;
            r_ofs     <= bus.LdAddr[1:0];
            r_cnt     <= 8'd0;
         end else if (r_state == ST_ISSUE) begin
            if (w_state_nx != ST_ISSUE) begin
               r_memreq <= 1'b0;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end
         if (w_capture) begin
            r_lddata <= w_ext;
         end
      end
   end

   assign bus.MemReq  = r_memreq;
   assign bus.MemAddr = r_memaddr;
   assign bus.LdData  = r_lddata;
   assign bus.LdValid = (r_state == ST_DONE);
   assign bus.Err     = r_err;
   assign bus.Stall   = ((r_state == ST_ISSUE) & ~bus.Flush) | w_accept;

endmodule

`default_nettype wire

// File: tb/tb_load_extend_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_load_extend_ctrl                                                |
// | Directed self-checking bench for load_extend_ctrl (TIMEOUT=4).     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_load_extend_ctrl;

   logic Clk;
   logic Reset_n;
   int   n_cmp;
   int   n_bad;

   load_extend_ctrl_if bus();

   load_extend_ctrl #(.TIMEOUT(4)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic req, input logic [2:0] ty, input logic [31:0] addr,
                        input logic ack, input logic [31:0] rdata, input logic flush);
      bus.LdReq    = req;
      bus.LdType   = ty;
      bus.LdAddr   = addr;
      bus.MemAck   = ack;
      bus.MemRdata = rdata;
      bus.Flush    = flush;
      #1;
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      Reset_n = 1'b0;
      drive(1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      chk("rst_memreq",  {31'd0, bus.MemReq},  32'd0);
      chk("rst_memaddr", bus.MemAddr,          32'd0);
      chk("rst_lddata",  bus.LdData,           32'd0);
      chk("rst_ldvalid", {31'd0, bus.LdValid}, 32'd0);
      chk("rst_err",     {31'd0, bus.Err},     32'd0);
      chk("rst_stall",   {31'd0, bus.Stall},   32'd0);
      cyc();
      cyc();
      Reset_n = 1'b1;
      cyc();

      // lb at 0x1003, ack in the first MemReq cycle
      drive(1'b1, 3'b011, 32'h0000_1003, 1'b0, 32'd0, 1'b0);
      chk("lb_stall_c0", {31'd0, bus.Stall}, 32'd1);
      cyc();
      drive(1'b0, 3'b011, 32'h0000_1003, 1'b1, 32'h80FF_1234, 1'b0);
      chk("lb_memreq_c1",  {31'd0, bus.MemReq},  32'd1);
      chk("lb_memaddr_c1", bus.MemAddr,          32'h0000_1000);
      chk("lb_stall_c1",   {31'd0, bus.Stall},   32'd1);
      chk("lb_ldvalid_c1", {31'd0, bus.LdValid}, 32'd0);
      cyc();
      drive(1'b0, 3'b011, 32'h0000_1003, 1'b0, 32'd0, 1'b0);
      chk("lb_ldvalid_c2", {31'd0, bus.LdValid}, 32'd1);
      chk("lb_lddata_c2",  bus.LdData,           32'hFFFF_FF80);
      chk("lb_memreq_c2",  {31'd0, bus.MemReq},  32'd0);
      chk("lb_stall_c2",   {31'd0, bus.Stall},   32'd0);
      chk("lb_err_c2",     {31'd0, bus.Err},     32'd0);
      cyc();
      chk("lb_ldvalid_c3", {31'd0, bus.LdValid}, 32'd0);

      // lhu then lh back-to-back at 0x2002
      drive(1'b1, 3'b010, 32'h0000_2002, 1'b0, 32'd0, 1'b0);
      cyc();
      drive(1'b0, 3'b010, 32'h0000_2002, 1'b1, 32'h9ABC_0000, 1'b0);
      chk("lhu_memaddr", bus.MemAddr, 32'h0000_2000);
      cyc();
      drive(1'b1, 3'b001, 32'h0000_2002, 1'b0, 32'd0, 1'b0);
      chk("lhu_ldvalid",   {31'd0, bus.LdValid}, 32'd1);
      chk("lhu_lddata",    bus.LdData,           32'h0000_9ABC);
      chk("b2b_stall_done", {31'd0, bus.Stall},  32'd1);
      cyc();
      drive(1'b0, 3'b001, 32'h0000_2002, 1'b1, 32'h9ABC_0000, 1'b0);
      chk("b2b_memreq",  {31'd0, bus.MemReq},  32'd1);
      chk("b2b_ldvalid", {31'd0, bus.LdValid}, 32'd0);
      cyc();
      drive(1'b0, 3'b001, 32'h0000_2002, 1'b0, 32'd0, 1'b0);
      chk("lh_ldvalid", {31'd0, bus.LdValid}, 32'd1);
      chk("lh_lddata",  bus.LdData,           32'hFFFF_9ABC);
      cyc();

      // misaligned lw
      drive(1'b1, 3'b000, 32'h0000_3001, 1'b0, 32'd0, 1'b0);
      chk("mis_stall", {31'd0, bus.Stall}, 32'd0);
      cyc();
      drive(1'b0, 3'b000, 32'h0000_3001, 1'b0, 32'd0, 1'b0);
      chk("mis_memreq",  {31'd0, bus.MemReq},  32'd0);
      chk("mis_err",     {31'd0, bus.Err},     32'd1);
      chk("mis_ldvalid", {31'd0, bus.LdValid}, 32'd0);
      chk("mis_lddata",  bus.LdData,           32'hFFFF_9ABC);
      cyc();
      chk("mis_err_drop", {31'd0, bus.Err}, 32'd0);

      // timeout with MemAck held low
      drive(1'b1, 3'b000, 32'h0000_4000, 1'b0, 32'd0, 1'b0);
      cyc();
      drive(1'b0, 3'b000, 32'h0000_4000, 1'b0, 32'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("tmo_memreq_%0d", i), {31'd0, bus.MemReq}, 32'd1);
         chk($sformatf("tmo_stall_%0d", i),  {31'd0, bus.Stall},  32'd1);
         chk($sformatf("tmo_err_%0d", i),    {31'd0, bus.Err},    32'd0);
         cyc();
      end
      chk("tmo_memreq_end", {31'd0, bus.MemReq},  32'd0);
      chk("tmo_err",        {31'd0, bus.Err},     32'd1);
      chk("tmo_stall_end",  {31'd0, bus.Stall},   32'd0);
      chk("tmo_ldvalid",    {31'd0, bus.LdValid}, 32'd0);
      cyc();
      chk("tmo_err_drop", {31'd0, bus.Err}, 32'd0);

      // flush with a same-cycle ack in the second ISSUE cycle
      drive(1'b1, 3'b100, 32'h0000_5001, 1'b0, 32'd0, 1'b0);
      cyc();
      drive(1'b0, 3'b100, 32'h0000_5001, 1'b0, 32'd0, 1'b0);
      chk("fl_memreq_c1", {31'd0, bus.MemReq}, 32'd1);
      cyc();
      drive(1'b0, 3'b100, 32'h0000_5001, 1'b1, 32'h1234_5678, 1'b1);
      chk("fl_stall", {31'd0, bus.Stall}, 32'd0);
      cyc();
      drive(1'b1, 3'b100, 32'h0000_5001, 1'b0, 32'd0, 1'b0);
      chk("fl_ldvalid", {31'd0, bus.LdValid}, 32'd0);
      chk("fl_err",     {31'd0, bus.Err},     32'd0);
      chk("fl_memreq",  {31'd0, bus.MemReq},  32'd0);
      chk("fl_lddata",  bus.LdData,           32'hFFFF_9ABC);
      cyc();
      drive(1'b0, 3'b100, 32'h0000_5001, 1'b1, 32'h0000_A500, 1'b0);
      chk("fl_next_memreq", {31'd0, bus.MemReq}, 32'd1);
      cyc();
      drive(1'b0, 3'b100, 32'h0000_5001, 1'b0, 32'd0, 1'b0);
      chk("fl_next_ldvalid", {31'd0, bus.LdValid}, 32'd1);
      chk("fl_next_lddata",  bus.LdData,           32'h0000_00A5);
      cyc();

      // asynchronous reset in the middle of ISSUE
      drive(1'b1, 3'b011, 32'h0000_6000, 1'b0, 32'd0, 1'b0);
      cyc();
      drive(1'b0, 3'b011, 32'h0000_6000, 1'b0, 32'd0, 1'b0);
      chk("rs_memreq_pre", {31'd0, bus.MemReq}, 32'd1);
      #1;
      Reset_n = 1'b0;
      #1;
      chk("rs_memreq",  {31'd0, bus.MemReq},  32'd0);
      chk("rs_lddata",  bus.LdData,           32'd0);
      chk("rs_ldvalid", {31'd0, bus.LdValid}, 32'd0);
      chk("rs_err",     {31'd0, bus.Err},     32'd0);
      chk("rs_stall",   {31'd0, bus.Stall},   32'd0);
      #1;
      Reset_n = 1'b1;
      drive(1'b0, 3'b011, 32'h0000_6000, 1'b1, 32'h0000_00FF, 1'b0);
      cyc();
      drive(1'b0, 3'b011, 32'h0000_6000, 1'b0, 32'd0, 1'b0);
      chk("rs_late_ldvalid", {31'd0, bus.LdValid}, 32'd0);
      chk("rs_late_memreq",  {31'd0, bus.MemReq},  32'd0);
      chk("rs_late_lddata",  bus.LdData,           32'd0);
      cyc();
      chk("rs_late_ldvalid2", {31'd0, bus.LdValid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/load_extend_ctrl.md
# load_extend_ctrl

Multi-cycle load controller between the pipeline's MEM stage and a variable-latency data memory. Issues a word-aligned memory request per load, waits on a req/ack handshake, selects the addressed byte or halfword lane, and sign- or zero-extends it to 32 bits. Stalls the pipeline while a load is outstanding, and flags misaligned accesses and memory timeouts.

## Interface
- TIMEOUT, 255: ISSUE cycles without MemAck before abort (1..255; counter 8 bits)
- Clk  in  1  sole clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- LdReq  in  1  pipeline requests a load this cycle
- LdType  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101–111 treated as lw
- LdAddr  in  32  byte address
- Flush  in  1  cancel any outstanding load
- MemReq  out  1  request to data memory, level, held until ack/flush/timeout
- MemAddr  out  32  {LdAddr[31:2],2'b00}, stable while MemReq=1
- MemAck  in  1  memory data valid this cycle
- MemRdata  in  32  read word, sampled when MemAck=1
- LdData  out  32  extended load result
- LdValid  out  1  one-cycle pulse, LdData valid
- Stall  out  1  combinational pipeline stall
- Err  out  1  one-cycle pulse: misaligned request or timeout

## Operation
- States: IDLE, ISSUE, DONE. Reset: IDLE, MemReq=0, MemAddr=0, LdData=0, LdValid=0, Err=0, timeout counter=0.
- Alignment: lw needs LdAddr[1:0]=00; lh/lhu need LdAddr[0]=0; lb/lbu always aligned.
- IDLE or DONE, LdReq=1, aligned: latch type and LdAddr[1:0]; next state ISSUE; MemReq=1, MemAddr loaded; counter cleared.
- IDLE or DONE, LdReq=1, misaligned: no memory request; Err=1 next cycle; next state IDLE.
- IDLE or DONE, LdReq=0: next state IDLE.
- ISSUE, MemAck=1 and Flush=0: LdData registered from MemRdata; MemReq=0; next state DONE.
- ISSUE, Flush=1: MemReq=0, next IDLE, no LdValid, no Err; MemAck in the same cycle discarded.
- ISSUE, no ack: counter increments; when counter reaches TIMEOUT-1 without ack, next state IDLE, MemReq=0, Err=1 next cycle.
- DONE: LdValid=1 for exactly this cycle; Flush ignored (result already delivered).
- Lane select, little-endian: byte offset 0 -> MemRdata[7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24]; halfword LdAddr[1]=0 -> [15:0], 1 -> [31:16].
- Extension: lb/lh replicate bit 7/15 into upper bits; lbu/lhu zero-fill; lw passes word unchanged.
- LdData holds its last value outside DONE, including after Err or Flush.
- MemAck outside ISSUE is ignored.

## Timing
- Stall = (state==ISSUE & ~Flush) | ((state==IDLE | state==DONE) & LdReq & aligned). No registered delay.
- Latency: LdReq accepted at edge 0; MemReq high from cycle 1; MemAck sampled high at edge k (k>=1); LdValid high cycle k+1. Minimum request-to-LdValid is 2 cycles.
- Back-to-back: LdReq during DONE is accepted; MemReq rises the cycle after DONE, so no bubble is inserted beyond the DONE cycle.
- Timeout: with no ack, MemReq is high for exactly TIMEOUT cycles and Err pulses on the following cycle.
- Reset_n low at any time forces the reset values immediately. A pending request is abandoned, and MemReq drops without waiting for an edge.
- Err and LdValid are never high in the same cycle.

## Test plan
- lb, LdAddr=0x1003, MemRdata=0x80FF_1234, ack 1 cycle after MemReq -> MemAddr=0x1000, LdData=0xFFFF_FF80, LdValid on cycle 2, Stall high cycles 0–1.
- lhu and lh, LdAddr=0x2002, MemRdata=0x9ABC_0000 -> lhu gives 0x0000_9ABC, lh gives 0xFFFF_9ABC; back-to-back issue has no extra stall cycle.
- lw, LdAddr=0x3001 -> no MemReq, Stall=0, Err pulse next cycle, LdData unchanged.
- TIMEOUT=4, MemAck tied low -> MemReq high 4 cycles, then Err pulse, state IDLE, Stall drops.
- Flush in cycle 2 of ISSUE with MemAck=1 in the same cycle -> no LdValid, LdData unchanged, next LdReq is served normally.
- Reset_n pulsed low mid-ISSUE -> MemReq, LdValid, Err, LdData all 0 immediately; a later MemAck is ignored.
